// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one ALU operand path between cores
//
// Grants one requesting core at a time. Drives the 3-bit ALUMUX select from the
// winner's code, then runs a fixed-latency sequence: start pulse, busy hold, and a
// done pulse back to the owner.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   req          in   [NUM_CORES]   per-core request level, sampled only while idle
//   src_sel      in   [3*NUM_CORES] per-core ALUMUX code, core k at [3k+2:3k]
//   grant        out  [NUM_CORES]   one-hot owner of the ALU path, zero when free
//   alu_mux_sel  out  [3]           ALUMUX select, 000 when nothing is granted
//   alu_start    out                pulse in the first busy cycle
//   busy         out                high while an operation is in flight or completing
//   done         out  [NUM_CORES]   completion pulse to the owner
//   err          out  [NUM_CORES]   pulse when the winning request carries an illegal code
module alu_share_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CORES-1:0]     req,
  input  logic [3*NUM_CORES-1:0]   src_sel,
  output logic [NUM_CORES-1:0]     grant,
  output logic [2:0]               alu_mux_sel,
  output logic                     alu_start,
  output logic                     busy,
  output logic [NUM_CORES-1:0]     done,
  output logic [NUM_CORES-1:0]     err
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [3:0]     cnt;

  logic                  found;
  logic [PW-1:0]         win_idx;
  logic [2:0]            win_code;
  logic                  win_legal;
  logic [NUM_CORES-1:0]  win_onehot;
  logic [PW-1:0]         ptr_next;
  int                    j;
  int                    win_int;

  // Rotating scan starting at ptr; the index wraps explicitly so non power-of-two
  // core counts never visit a nonexistent core.
  always_comb begin
    found   = 1'b0;
    win_int = 0;
    j       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_int = j;
      end
    end
    win_idx    = PW'(win_int);
    win_code   = src_sel[3*win_int +: 3];
    win_legal  = (win_code != 3'b000) && (win_code <= 3'b101);
    win_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_idx;
    ptr_next   = (win_idx == PW'(NUM_CORES-1)) ? '0 : win_idx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      alu_mux_sel <= 3'b000;
      alu_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= '0;
      err         <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant       <= '0;
          alu_mux_sel <= 3'b000;
          alu_start   <= 1'b0;
          busy        <= 1'b0;
          done        <= '0;
          err         <= '0;
          if (found) begin
            // The pointer advances past the winner even on an illegal code so a
            // core stuck on a bad code cannot starve the others.
            ptr <= ptr_next;
            if (win_legal) begin
              grant       <= win_onehot;
              alu_mux_sel <= win_code;
              alu_start   <= 1'b1;
              busy        <= 1'b1;
              cnt         <= 4'(ALU_LATENCY - 1);
              state       <= BUSY;
            end else begin
              err <= win_onehot;
            end
          end
        end
        BUSY: begin
          alu_start <= 1'b0;
          if (cnt == 4'd0) begin
            done  <= grant;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          done        <= '0;
          grant       <= '0;
          alu_mux_sel <= 3'b000;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] src_sel;
  logic [N-1:0]   grant;
  logic [2:0]     alu_mux_sel;
  logic           alu_start;
  logic           busy;
  logic [N-1:0]   done;
  logic [N-1:0]   err;

  alu_share_arbiter #(.NUM_CORES(N), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req(req), .src_sel(src_sel),
    .grant(grant), .alu_mux_sel(alu_mux_sel), .alu_start(alu_start),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: an operation is tracked as "cycles since grant" t; start at t=1,
  // done at t=L+1, released the cycle after.
  int         m_owner = -1;
  int         m_t = 0;
  int         m_ptr = 0;
  logic [2:0] m_sel = 3'b000;
  logic [N-1:0] m_err = '0;

  task automatic m_step();
    int k;
    logic [2:0] code;
    if (rst) begin
      m_owner = -1; m_t = 0; m_ptr = 0; m_sel = 3'b000; m_err = '0;
    end else if (m_owner >= 0) begin
      m_err = '0;
      if (m_t == L + 1) begin
        m_owner = -1; m_t = 0; m_sel = 3'b000;
      end else begin
        m_t++;
      end
    end else begin
      m_err = '0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (req[k]) begin
          code = src_sel[3*k +: 3];
          if (code >= 3'd1 && code <= 3'd5) begin
            m_owner = k; m_t = 1; m_sel = code;
          end else begin
            m_err = N'(1) << k;
          end
          m_ptr = (k + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, " sel"},   32'(alu_mux_sel), 32'(m_sel));
    chk({tag, " start"}, 32'(alu_start), 32'(m_owner >= 0 && m_t == 1));
    chk({tag, " busy"},  32'(busy), 32'(m_owner >= 0));
    chk({tag, " done"},  32'(done), (m_owner >= 0 && m_t == L + 1) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, " err"},   32'(err), 32'(m_err));
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] rq;
    logic [N-1:0] g;
    logic [2:0]   sel;
    logic         st;
    logic         bz;
    logic [N-1:0] dn;
    logic [N-1:0] er;
  } vec_t;

  vec_t vecs[13];

  logic [3:0] exp_g[5];
  logic [2:0] exp_s[5];
  int n;

  initial begin
    // core0 IR, core1 illegal 110, core2 IDY, core3 R5
    vecs[0]  = '{1'b0, 4'b0001, 4'b0001, 3'b001, 1'b1, 1'b1, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 3'b001, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0001, 3'b001, 1'b0, 1'b1, 4'b0001, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0010};
    vecs[5]  = '{1'b0, 4'b0110, 4'b0100, 3'b011, 1'b1, 1'b1, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0100, 3'b011, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0100, 3'b011, 1'b0, 1'b1, 4'b0100, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1001, 4'b1000, 3'b101, 1'b1, 1'b1, 4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 4'b1001, 4'b1000, 3'b101, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 4'b1001, 4'b1000, 3'b101, 1'b0, 1'b1, 4'b1000, 4'b0000};
    vecs[12] = '{1'b1, 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000};

    rst = 1'b1; req = '0; src_sel = '0;

    // reset state
    do_reset();
    chk("rst grant", 32'(grant), 0);
    chk("rst sel", 32'(alu_mux_sel), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst start", 32'(alu_start), 0);

    // table: single grant, illegal code, rotation past erroring core
    src_sel = {3'b101, 3'b011, 3'b110, 3'b001};
    foreach (vecs[i]) begin
      rst = vecs[i].r; req = vecs[i].rq;
      tick();
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("vec%0d sel", i), 32'(alu_mux_sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d start", i), 32'(alu_start), 32'(vecs[i].st));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bz));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].er));
    end

    // all four requesting: strict rotation, one op every L+2 cycles
    do_reset();
    src_sel = {3'b010, 3'b100, 3'b101, 3'b001};
    req = 4'b1111;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{3'b001, 3'b101, 3'b100, 3'b010, 3'b001};
    for (int op = 0; op < 5; op++) begin
      n = 0;
      while (!alu_start && n < 10) begin tick(); n++; end
      chk($sformatf("rr%0d start", op), 32'(alu_start), 1);
      chk($sformatf("rr%0d grant", op), 32'(grant), 32'(exp_g[op]));
      chk($sformatf("rr%0d sel", op), 32'(alu_mux_sel), 32'(exp_s[op]));
      if (op > 0) chk($sformatf("rr%0d spacing", op), n, L + 1);
      tick();
    end

    // source change and request drop mid-operation are ignored
    do_reset();
    src_sel = {3'b000, 3'b000, 3'b101, 3'b000};
    req = 4'b0010;
    tick();
    chk("hold grant", 32'(grant), 32'b0010);
    src_sel = {3'b000, 3'b000, 3'b011, 3'b000};
    req = 4'b0000;
    tick();
    chk("hold sel busy", 32'(alu_mux_sel), 32'b101);
    tick();
    chk("hold sel done", 32'(alu_mux_sel), 32'b101);
    chk("hold done", 32'(done), 32'b0010);
    tick();
    chk("hold release", 32'(grant), 0);

    // reset in the middle of an operation; pointer returns to core0
    do_reset();
    src_sel = {3'b001, 3'b001, 3'b001, 3'b001};
    req = 4'b0010;
    tick();
    chk("mid grant", 32'(grant), 32'b0010);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("mid rst grant", 32'(grant), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst sel", 32'(alu_mux_sel), 0);
    tick();
    chk("mid rst no done", 32'(done), 0);
    req = 4'b1111;
    tick();
    chk("mid rst ptr", 32'(grant), 32'b0001);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = N'($urandom);
      src_sel = (3*N)'($urandom);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
